// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing bundle of the multi-cycle controller: run/instruction/ready/flag inputs in,
// decoded control strobes and status out. master = controller, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [31:0]      ins;
    logic             imem_ready;
    logic             dmem_ready;
    logic             zero;
    logic             RegWrite;
    logic             ALUSrc;
    logic             Mem2Reg;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       op;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic [31:0]      ir;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, ins, imem_ready, dmem_ready, zero,
        output RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op, pc_write, pc_sel,
        output ir, state, halted, illegal, retired
    );

    modport slave (
        output run, ins, imem_ready, dmem_ready, zero,
        input  RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op, pc_write, pc_sel,
        input  ir, state, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM, one state per clock: beq 3, R/I/store/jal 4, load 5 cycles with ready=1.
// FETCH stalls on imem_ready and MEM stalls on dmem_ready; illegal or zero instructions halt until reset.
module multicycle_ctrl #(
    parameter int CNT_W        = 16,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state_q, state_d, boundary_state;
    logic [31:0]      ir_q, ir_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic [6:0]       opc;
    logic             is_load;
    logic             is_sub;
    logic             legal;

    assign opc     = ir_q[6:0];
    assign is_load = (opc == OP_LD);
    assign is_sub  = (opc == OP_R) && (ir_q[31:25] == 7'h20);
    assign legal   = opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_BEQ, OP_JAL};

    // run only matters between instructions; a drop mid-instruction lets it finish
    assign boundary_state = bus.run ? S_FETCH : S_IDLE;

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b010:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.Mem2Reg  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.op       = ALU_ADD;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 2'd0;

        case (state_q)
            S_IDLE: if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.ins;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if ((HALT_ON_ZERO != 0) && (ir_q == 32'd0)) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                bus.ALUSrc = !(opc == OP_R || opc == OP_BEQ);
                case (opc)
                    OP_R, OP_I: begin
                        bus.op  = alu_op(ir_q[14:12], is_sub);
                        state_d = S_WB;
                    end
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_JAL:       state_d = S_WB;
                    OP_BEQ: begin
                        bus.op       = ALU_SUB;
                        bus.pc_sel   = bus.zero ? 2'd1 : 2'd0;
                        bus.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = boundary_state;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                bus.MemRead  = is_load;
                bus.MemWrite = !is_load;
                if (bus.dmem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        bus.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = boundary_state;
                    end
                end
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = is_load;
                bus.pc_write = 1'b1;
                bus.pc_sel   = (opc == OP_JAL) ? 2'd2 : 2'd0;
                retire       = 1'b1;
                state_d      = boundary_state;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign bus.ir      = ir_q;
    assign bus.state   = state_q;
    assign bus.halted  = halted_q;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;
endmodule
